leaf_out_packetizer: RTL and testbench

- Output-side stage between a user kernel output stream and the BFT-facing packet path of a leaf.
- Accepts 32-bit payload words with a vld/ack handshake and wraps each word in a 49-bit BFT packet: valid, destination leaf, destination port, receiver BRAM address, payload.
- Tracks credits against the remote receiver's BRAM so packets are never sent without buffer space.
- One instance per user output port, in the leaf's interface clock domain.

---
 rtl/leaf_out_packetizer.sv | 148 ++++++++++++++
 tb/tb_leaf_out_packetizer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_packetizer.sv
// +-----------------------------------------------------------------------------+
// | Module      : leaf_out_packetizer                                           |
// | Description : Wraps user output words into BFT packets and tracks credits   |
// |               against the remote receiver BRAM.                             |
// | Options     : LEAF_PKT_STATS_EN adds pkt_count / stall_cycles counters.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module leaf_out_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_wr,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
    input  logic [PAYLOAD_BITS-1:0]  din_user2pkt,
    input  logic                     vld_user2pkt,
    output logic                     ack_pkt2user,
    input  logic                     credit_return,
    output logic [PACKET_BITS-1:0]   dout_pkt2arb,
    input  logic                     ack_arb2pkt,
    output logic [NUM_ADDR_BITS:0]   free_space,
    output logic                     configured,
    output logic                     err_credit_ovf
`ifdef LEAF_PKT_STATS_EN
    ,
    output logic [31:0]              pkt_count,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int c_fs_w = NUM_ADDR_BITS + 2;

    localparam logic [1:0] c_st_uncfg  = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_nocred = 2'd2;

    localparam logic [NUM_ADDR_BITS:0] c_depth_cnt = {1'b1, {NUM_ADDR_BITS{1'b0}}};
    localparam logic [c_fs_w-1:0]      c_depth_fs  = {2'b01, {NUM_ADDR_BITS{1'b0}}};
    localparam logic [c_fs_w-1:0]      c_update_fs = c_fs_w'(FREESPACE_UPDATE_SIZE);
    localparam logic [c_fs_w-1:0]      c_one_fs    = c_fs_w'(1);
    localparam logic [NUM_ADDR_BITS-1:0] c_one_ptr = NUM_ADDR_BITS'(1);

    logic [1:0]               r_state;
    logic [NUM_LEAF_BITS-1:0] r_dest_leaf;
    logic [NUM_PORT_BITS-1:0] r_dest_port;
    logic [NUM_ADDR_BITS-1:0] r_wr_ptr;
    logic [NUM_ADDR_BITS:0]   r_free_space;
    logic [PACKET_BITS-1:0]   r_dout;
    logic                     r_configured;
    logic                     r_err_ovf;

    logic                     w_out_valid;
    logic                     w_accept;
    logic                     w_drain;
    logic [c_fs_w-1:0]        w_fs_next;
    logic                     w_fs_ovf;
    logic [NUM_ADDR_BITS:0]   w_fs_clamped;

    assign w_out_valid = r_dout[PACKET_BITS-1];
    assign w_drain     = w_out_valid & ack_arb2pkt;
    assign w_accept    = vld_user2pkt & (r_state == c_st_run) & ~cfg_wr
                         & (~w_out_valid | ack_arb2pkt);

    // Extra headroom bit lets an over-return be detected before clamping.
    assign w_fs_next    = {1'b0, r_free_space}
                          + (credit_return ? c_update_fs : '0)
                          - (w_accept ? c_one_fs : '0);
    assign w_fs_ovf     = (w_fs_next > c_depth_fs);
    assign w_fs_clamped = w_fs_ovf ? c_depth_cnt : w_fs_next[NUM_ADDR_BITS:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_uncfg;
            r_dest_leaf  <= '0;
            r_dest_port  <= '0;
            r_wr_ptr     <= '0;
            r_free_space <= c_depth_cnt;
            r_dout       <= '0;
            r_configured <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else if (cfg_wr) begin
            // Any pending packet keeps its old header; credits in this cycle are dropped.
            r_state      <= c_st_run;
            r_dest_leaf  <= cfg_dest_leaf;
            r_dest_port  <= cfg_dest_port;
            r_wr_ptr     <= '0;
            r_free_space <= c_depth_cnt;
            r_configured <= 1'b1;
            if (w_drain) begin
                r_dout <= '0;
            end
        end else begin
            if (w_accept) begin
                r_dout   <= {1'b1, r_dest_leaf, r_dest_port, r_wr_ptr, din_user2pkt};
                r_wr_ptr <= r_wr_ptr + c_one_ptr;
            end else if (w_drain) begin
                r_dout <= '0;
            end
            r_free_space <= w_fs_clamped;
            if (w_fs_ovf) begin
                r_err_ovf <= 1'b1;
            end
            if (r_state != c_st_uncfg) begin
                r_state <= (w_fs_clamped == '0) ? c_st_nocred : c_st_run;
            end
        end
    end

`ifdef LEAF_PKT_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset || cfg_wr) begin
            r_pkt_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_drain) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (vld_user2pkt && (r_state == c_st_nocred) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign pkt_count    = r_pkt_count;
    assign stall_cycles = r_stall_cycles;
`endif

    assign ack_pkt2user   = w_accept;
    assign dout_pkt2arb   = r_dout;
    assign free_space     = r_free_space;
    assign configured     = r_configured;
    assign err_credit_ovf = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_leaf_out_packetizer.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_leaf_out_packetizer                                        |
// | Description : Self-checking bench: vector table plus multi-cycle sequences. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_leaf_out_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr;
    logic [4:0]  cfg_dest_leaf;
    logic [3:0]  cfg_dest_port;
    logic [31:0] din_user2pkt;
    logic        vld_user2pkt;
    logic        ack_pkt2user;
    logic        credit_return;
    logic [48:0] dout_pkt2arb;
    logic        ack_arb2pkt;
    logic [7:0]  free_space;
    logic        configured;
    logic        err_credit_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    leaf_out_packetizer dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_wr         (cfg_wr),
        .cfg_dest_leaf  (cfg_dest_leaf),
        .cfg_dest_port  (cfg_dest_port),
        .din_user2pkt   (din_user2pkt),
        .vld_user2pkt   (vld_user2pkt),
        .ack_pkt2user   (ack_pkt2user),
        .credit_return  (credit_return),
        .dout_pkt2arb   (dout_pkt2arb),
        .ack_arb2pkt    (ack_arb2pkt),
        .free_space     (free_space),
        .configured     (configured),
        .err_credit_ovf (err_credit_ovf)
    );

    typedef struct packed {
        logic        vld;
        logic [31:0] din;
        logic        arb;
        logic        cfg;
        logic [4:0]  leaf;
        logic [3:0]  port;
        logic        cr;
        logic        exp_ack;
        logic [48:0] exp_dout;
        logic [7:0]  exp_free;
        logic        exp_cfg;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [48:0] pkt(input logic [4:0] leaf, input logic [3:0] port,
                                        input logic [6:0] addr, input logic [31:0] pay);
        return {1'b1, leaf, port, addr, pay};
    endfunction

    function automatic vec_t mk(input logic vld, input logic [31:0] din, input logic arb,
                                input logic cfg, input logic [4:0] leaf, input logic [3:0] port,
                                input logic cr, input logic ea, input logic [48:0] ed,
                                input logic [7:0] ef, input logic ec, input logic eo);
        vec_t v;
        v.vld = vld; v.din = din; v.arb = arb; v.cfg = cfg; v.leaf = leaf; v.port = port;
        v.cr = cr; v.exp_ack = ea; v.exp_dout = ed; v.exp_free = ef; v.exp_cfg = ec; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic vld, input logic [31:0] din, input logic arb,
                          input logic cfg, input logic [4:0] leaf, input logic [3:0] port,
                          input logic cr);
        vld_user2pkt  = vld;
        din_user2pkt  = din;
        ack_arb2pkt   = arb;
        cfg_wr        = cfg;
        cfg_dest_leaf = leaf;
        cfg_dest_port = port;
        credit_return = cr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic do_cfg(input logic [4:0] leaf, input logic [3:0] port);
        set_in(1'b0, 32'h0, 1'b1, 1'b1, leaf, port, 1'b0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1, 32'h11, 0, 0, 0, 0, 0, 0, 49'h0,                   8'd128, 0, 0);
        vecs[1]  = mk(1, 32'h22, 0, 1, 5, 3, 0, 0, 49'h0,                   8'd128, 1, 0);
        vecs[2]  = mk(1, 32'hA0, 1, 0, 0, 0, 0, 1, pkt(5, 3, 0, 32'hA0),   8'd127, 1, 0);
        vecs[3]  = mk(1, 32'hA1, 1, 0, 0, 0, 0, 1, pkt(5, 3, 1, 32'hA1),   8'd126, 1, 0);
        vecs[4]  = mk(1, 32'hA2, 1, 0, 0, 0, 0, 1, pkt(5, 3, 2, 32'hA2),   8'd125, 1, 0);
        vecs[5]  = mk(1, 32'hA3, 1, 0, 0, 0, 0, 1, pkt(5, 3, 3, 32'hA3),   8'd124, 1, 0);
        vecs[6]  = mk(0, 32'h0,  1, 0, 0, 0, 0, 0, 49'h0,                   8'd124, 1, 0);
        vecs[7]  = mk(1, 32'hB0, 0, 0, 0, 0, 0, 1, pkt(5, 3, 4, 32'hB0),   8'd123, 1, 0);
        vecs[8]  = mk(1, 32'hB1, 0, 0, 0, 0, 0, 0, pkt(5, 3, 4, 32'hB0),   8'd123, 1, 0);
        vecs[9]  = mk(1, 32'hB1, 0, 0, 0, 0, 0, 0, pkt(5, 3, 4, 32'hB0),   8'd123, 1, 0);
        vecs[10] = mk(1, 32'hB1, 1, 0, 0, 0, 0, 1, pkt(5, 3, 5, 32'hB1),   8'd122, 1, 0);
        vecs[11] = mk(0, 32'h0,  1, 0, 0, 0, 0, 0, 49'h0,                   8'd122, 1, 0);

        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        tick();
        tick();
        vld_user2pkt = 1'b1;
        #1;
        chk("rst_ack", ack_pkt2user, 0);
        chk("rst_dout", dout_pkt2arb, 0);
        chk("rst_free", free_space, 128);
        chk("rst_cfg", configured, 0);
        chk("rst_ovf", err_credit_ovf, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].vld, vecs[i].din, vecs[i].arb, vecs[i].cfg,
                   vecs[i].leaf, vecs[i].port, vecs[i].cr);
            #1;
            chk($sformatf("vec%0d_ack", i), ack_pkt2user, vecs[i].exp_ack);
            tick();
            chk($sformatf("vec%0d_dout", i), dout_pkt2arb, vecs[i].exp_dout);
            chk($sformatf("vec%0d_free", i), free_space, vecs[i].exp_free);
            chk($sformatf("vec%0d_cfg", i), configured, vecs[i].exp_cfg);
            chk($sformatf("vec%0d_ovf", i), err_credit_ovf, vecs[i].exp_ovf);
        end

        // Exhaust credits, stall, then recover with one credit pulse.
        do_reset();
        do_cfg(5'd5, 4'd3);
        for (int i = 0; i < 128; i++) begin
            set_in(1'b1, 32'hC000 + i, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
            #1;
            chk("fill_ack", ack_pkt2user, 1);
            tick();
            chk("fill_dout", dout_pkt2arb, pkt(5, 3, 7'(i), 32'hC000 + i));
            chk("fill_free", free_space, 127 - i);
        end
        set_in(1'b1, 32'hD0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nocred_ack", ack_pkt2user, 0);
            tick();
        end
        chk("nocred_dout", dout_pkt2arb, 0);
        chk("nocred_free", free_space, 0);
        credit_return = 1'b1;
        #1;
        chk("credit_cycle_ack", ack_pkt2user, 0);
        tick();
        chk("credit_free", free_space, 64);
        credit_return = 1'b0;
        #1;
        chk("recover_ack", ack_pkt2user, 1);
        tick();
        chk("wrap_dout", dout_pkt2arb, pkt(5, 3, 0, 32'hD0));
        chk("recover_free", free_space, 63);
        set_in(1'b1, 32'hD1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b1);
        #1;
        chk("cr_acc_ack", ack_pkt2user, 1);
        tick();
        chk("cr_acc_free", free_space, 126);
        chk("cr_acc_dout", dout_pkt2arb, pkt(5, 3, 1, 32'hD1));

        // Credit overflow is clamped and sticky until reset.
        do_reset();
        do_cfg(5'd5, 4'd3);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b1);
        tick();
        chk("ovf_free", free_space, 128);
        chk("ovf_flag", err_credit_ovf, 1);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        tick();
        tick();
        chk("ovf_sticky", err_credit_ovf, 1);
        do_cfg(5'd2, 4'd2);
        chk("ovf_after_cfg", err_credit_ovf, 1);
        do_reset();
        chk("ovf_cleared", err_credit_ovf, 0);

        // Reconfigure while a packet is pending.
        do_cfg(5'd5, 4'd3);
        set_in(1'b1, 32'hC0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        tick();
        set_in(1'b1, 32'hC1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        tick();
        chk("pre_cfg_dout", dout_pkt2arb, pkt(5, 3, 1, 32'hC1));
        chk("pre_cfg_free", free_space, 126);
        set_in(1'b1, 32'hC2, 1'b0, 1'b1, 5'd9, 4'd1, 1'b1);
        #1;
        chk("cfg_block_ack", ack_pkt2user, 0);
        tick();
        chk("cfg_hold_dout", dout_pkt2arb, pkt(5, 3, 1, 32'hC1));
        chk("cfg_free", free_space, 128);
        chk("cfg_cr_discard", err_credit_ovf, 0);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        #1;
        chk("old_hdr_exit", dout_pkt2arb, pkt(5, 3, 1, 32'hC1));
        tick();
        chk("old_drained", dout_pkt2arb, 0);
        set_in(1'b1, 32'hC2, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        #1;
        chk("new_cfg_ack", ack_pkt2user, 1);
        tick();
        chk("new_hdr_dout", dout_pkt2arb, pkt(9, 1, 0, 32'hC2));
        chk("new_hdr_free", free_space, 127);

        // Reset while a packet is pending and vld is high.
        set_in(1'b1, 32'hE0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0);
        tick();
        chk("pend_dout", dout_pkt2arb, pkt(9, 1, 1, 32'hE0));
        reset = 1'b1;
        set_in(1'b1, 32'hE1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        tick();
        chk("midrst_dout", dout_pkt2arb, 0);
        chk("midrst_cfg", configured, 0);
        chk("midrst_free", free_space, 128);
        chk("midrst_ack", ack_pkt2user, 0);
        reset = 1'b0;
        #1;
        chk("uncfg_ack", ack_pkt2user, 0);
        tick();
        chk("uncfg_dout", dout_pkt2arb, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
